// File: rtl/lx32_arch_pkg.sv
// LX32 architectural defaults and front-end bundle types.
package lx32_arch_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/lx32_isa_pkg.sv
// LX32 ISA constants shared by the front end.
package lx32_isa_pkg;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/fetch_fifo.sv
// Instruction queue storage for the fetch unit: circular buffer with flush.
module fetch_fifo
    import lx32_arch_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    localparam int unsigned AW = $clog2(DEPTH),
    localparam int unsigned CW = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_i,
    input  fetch_entry_t  data_i,
    input  logic          pop_i,
    input  logic          flush_i,
    output fetch_entry_t  data_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [CW-1:0] count_o
);

    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    fetch_entry_t  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] wr_ptr_d;
    logic [AW-1:0] rd_ptr_q;
    logic [AW-1:0] rd_ptr_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          do_push;
    logic          do_pop;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == FULL_CNT);
    assign count_o = cnt_q;
    assign data_o  = mem_q[rd_ptr_q];

    // A full queue still accepts a push when the head leaves in the same cycle.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   cnt_d = cnt_q + CW'(1);
                2'b01:   cnt_d = cnt_q - CW'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush_i) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/fetch_queue.sv
// Fetch unit: issues sequential imem requests and queues responses for decode.
// Define LX32_FETCH_PERF_EN to add the perf_fetch_cnt delivered-instruction counter.
module fetch_queue
    import lx32_arch_pkg::*;
    import lx32_isa_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = RESET_PC_DEFAULT,
    parameter int unsigned QUEUE_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
`ifdef LX32_FETCH_PERF_EN
    output logic [31:0] perf_fetch_cnt,
`endif
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc
);

    localparam int unsigned   AW      = $clog2(QUEUE_DEPTH);
    localparam int unsigned   CW      = AW + 1;
    localparam logic [CW:0]   DEPTH_C = (CW + 1)'(QUEUE_DEPTH);

    logic [31:0]  pc_q;
    logic [31:0]  pc_d;
    logic [31:0]  rsp_pc_q;
    logic [31:0]  rsp_pc_d;
    logic [CW-1:0] out_q;
    logic [CW-1:0] out_d;
    logic [CW-1:0] stale_q;
    logic [CW-1:0] stale_d;
    logic [CW-1:0] fifo_cnt;
    logic [CW:0]  inflight;
    logic [31:0]  redir_pc;
    logic         req_hs;
    logic         rsp_hs;
    logic         live_rsp;
    logic         push;
    logic         pop;
    logic         fifo_full;
    logic         fifo_empty;
    fetch_entry_t wr_entry;
    fetch_entry_t head;

    assign redir_pc = redirect_pc & 32'hFFFF_FFFC;
    assign inflight = {1'b0, fifo_cnt} + {1'b0, out_q};

    // Outstanding requests include stale ones, so a slot is reserved per request.
    assign imem_req_valid = rst_n && (inflight < DEPTH_C);
    assign imem_req_addr  = pc_q;
    assign req_hs         = imem_req_valid && imem_req_ready;

    assign rsp_hs   = imem_rsp_valid && (out_q != '0);
    assign live_rsp = rsp_hs && (stale_q == '0) && !redirect_valid;

    // Responses return in order, so the oldest live request address is tracked.
    assign wr_entry = '{instr: imem_rsp_data, pc: rsp_pc_q};
    assign push     = live_rsp && (!fifo_full || pop);
    assign pop      = id_valid && id_ready;

    assign id_valid = !fifo_empty;
    assign id_instr = fifo_empty ? NOP_INSTR : head.instr;
    assign id_pc    = fifo_empty ? pc_q : head.pc;

    fetch_fifo #(
        .DEPTH   (QUEUE_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .data_i  (wr_entry),
        .pop_i   (pop),
        .flush_i (redirect_valid),
        .data_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_cnt)
    );

    always_comb begin
        pc_d     = pc_q;
        rsp_pc_d = rsp_pc_q;
        out_d    = out_q;
        stale_d  = stale_q;
        if (req_hs) begin
            pc_d  = pc_q + 32'd4;
            out_d = out_d + CW'(1);
        end
        if (rsp_hs) begin
            out_d = out_d - CW'(1);
            if (stale_q != '0) begin
                stale_d = stale_q - CW'(1);
            end
        end
        if (live_rsp) begin
            rsp_pc_d = rsp_pc_q + 32'd4;
        end
        // Everything still in flight after this cycle belongs to the old path.
        if (redirect_valid) begin
            pc_d     = redir_pc;
            rsp_pc_d = redir_pc;
            stale_d  = out_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q     <= RESET_PC;
            rsp_pc_q <= RESET_PC;
            out_q    <= '0;
            stale_q  <= '0;
        end else begin
            pc_q     <= pc_d;
            rsp_pc_q <= rsp_pc_d;
            out_q    <= out_d;
            stale_q  <= stale_d;
        end
    end

`ifdef LX32_FETCH_PERF_EN
    logic [31:0] perf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_q <= '0;
        end else if (pop) begin
            perf_q <= perf_q + 32'd1;
        end
    end

    assign perf_fetch_cnt = perf_q;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue with a pipelined memory model and id scoreboard.
module tb_fetch_queue;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        id_valid;
    logic        id_ready = 1'b0;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
`ifdef LX32_FETCH_PERF_EN
    logic [31:0] perf_fetch_cnt;
`endif

    typedef struct {
        logic [31:0] addr;
        int          ep;
    } pend_t;

    int          checks = 0;
    int          errors = 0;
    pend_t       pend_q[$];
    pend_t       mem_p;
    logic [63:0] exp_q[$];
    logic [63:0] sb_e;
    logic [31:0] req_log[$];
    int          epoch = 0;
    int          cur_ep = 0;
    logic [31:0] cur_addr = '0;
    int          id_hs_cnt = 0;
    bit          mem_en = 1'b1;

    fetch_queue #(
        .RESET_PC       (32'h0000_0000),
        .QUEUE_DEPTH    (2)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
`ifdef LX32_FETCH_PERF_EN
        .perf_fetch_cnt (perf_fetch_cnt),
`endif
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_instr       (id_instr),
        .id_pc          (id_pc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    function automatic logic [31:0] log_at(input int i);
        return (i < req_log.size()) ? req_log[i] : 32'hDEAD_BEEF;
    endfunction

    // Memory: answers each accepted request one or more cycles later, in order.
    always @(posedge clk) begin
        #2;
        if (rst_n && mem_en && pend_q.size() != 0) begin
            mem_p          = pend_q.pop_front();
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = ~mem_p.addr;
            cur_addr       = mem_p.addr;
            cur_ep         = mem_p.ep;
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
        end
    end

    // Scoreboard: live responses become expected decode entries next cycle.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            pend_q.delete();
            req_log.delete();
        end else begin
            chk("sb_id_valid", {31'b0, id_valid}, {31'b0, exp_q.size() != 0});
            if (id_valid && id_ready) begin
                id_hs_cnt++;
                if (exp_q.size() != 0) begin
                    sb_e = exp_q.pop_front();
                    chk("sb_id_pc", id_pc, sb_e[31:0]);
                    chk("sb_id_instr", id_instr, sb_e[63:32]);
                end
            end
            if (redirect_valid) begin
                exp_q.delete();
            end else if (imem_rsp_valid && cur_ep == epoch) begin
                exp_q.push_back({~cur_addr, cur_addr});
            end
            if (imem_req_valid && imem_req_ready) begin
                pend_q.push_back('{imem_req_addr, epoch});
                req_log.push_back(imem_req_addr);
            end
            if (redirect_valid) begin
                epoch++;
            end
        end
    end

    initial begin
        int  hs_base;
        int  rl;
        bit  found;

        // Reset values
        repeat (3) tick();
        imem_req_ready = 1'b1;
        at_neg();
        chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
        chk("rst_id_valid", {31'b0, id_valid}, 32'd0);
        chk("rst_id_instr", id_instr, 32'h0000_0013);
        chk("rst_id_pc", id_pc, 32'h0000_0000);

        // First request right after reset, first delivery two cycles later
        tick();
        rst_n    = 1'b1;
        id_ready = 1'b1;
        at_neg();
        chk("first_req_valid", {31'b0, imem_req_valid}, 32'd1);
        chk("first_req_addr", imem_req_addr, 32'h0000_0000);
        at_neg();
        chk("lat_id_valid_c1", {31'b0, id_valid}, 32'd0);
        at_neg();
        chk("lat_id_valid_c2", {31'b0, id_valid}, 32'd1);
        chk("lat_id_pc_c2", id_pc, 32'h0000_0000);
        repeat (12) at_neg();
        chk("seq_addr0", log_at(0), 32'h0000_0000);
        chk("seq_addr1", log_at(1), 32'h0000_0004);
        chk("seq_addr2", log_at(2), 32'h0000_0008);

        // Decode stalled: queue fills and requests stop
        tick();
        id_ready = 1'b0;
        hs_base  = req_log.size();
        repeat (10) at_neg();
        chk("hold_req_valid", {31'b0, imem_req_valid}, 32'd0);
        chk("hold_id_valid", {31'b0, id_valid}, 32'd1);
        chk("hold_req_count", {31'b0, (req_log.size() - hs_base) <= 2}, 32'd1);
        tick();
        id_ready = 1'b1;
        at_neg();
        chk("pop_cycle_req_valid", {31'b0, imem_req_valid}, 32'd0);
        tick();
        id_ready = 1'b0;
        at_neg();
        chk("after_pop_req_valid", {31'b0, imem_req_valid}, 32'd1);

        // Redirect with two requests outstanding
        tick();
        mem_en   = 1'b0;
        id_ready = 1'b1;
        repeat (8) at_neg();
        chk("outst_req_valid", {31'b0, imem_req_valid}, 32'd0);
        chk("outst_id_valid", {31'b0, id_valid}, 32'd0);
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_1002;
        tick();
        redirect_valid = 1'b0;
        rl             = req_log.size();
        at_neg();
        chk("redir_id_valid", {31'b0, id_valid}, 32'd0);
        chk("redir_empty_id_pc", id_pc, 32'h0000_1000);
        chk("redir_stale_block", {31'b0, imem_req_valid}, 32'd0);
        tick();
        mem_en = 1'b1;
        found  = 1'b0;
        for (int i = 0; i < 20; i++) begin
            at_neg();
            if (id_valid) begin
                found = 1'b1;
                break;
            end
        end
        chk("redir_deliver_seen", {31'b0, found}, 32'd1);
        chk("redir_first_id_pc", id_pc, 32'h0000_1000);
        chk("redir_first_addr", log_at(rl), 32'h0000_1000);
        repeat (6) at_neg();

        // Redirect in the same cycle as a response
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #3;
            if (imem_rsp_valid) begin
                found = 1'b1;
                break;
            end
        end
        chk("rsp_redir_seen", {31'b0, found}, 32'd1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_2000;
        tick();
        redirect_valid = 1'b0;
        at_neg();
        chk("rsp_redir_id_valid", {31'b0, id_valid}, 32'd0);
        chk("rsp_redir_id_pc", id_pc, 32'h0000_2000);
        repeat (10) at_neg();

        // Fetch PC wraps from the top of the address space
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFF8;
        tick();
        redirect_valid = 1'b0;
        rl             = req_log.size();
        at_neg();
        chk("wrap_id_valid", {31'b0, id_valid}, 32'd0);
        chk("wrap_id_pc", id_pc, 32'hFFFF_FFF8);
        repeat (12) at_neg();
        chk("wrap_addr0", log_at(rl), 32'hFFFF_FFF8);
        chk("wrap_addr1", log_at(rl + 1), 32'hFFFF_FFFC);
        chk("wrap_addr2", log_at(rl + 2), 32'h0000_0000);
        chk("wrap_addr3", log_at(rl + 3), 32'h0000_0004);

`ifdef LX32_FETCH_PERF_EN
        // Delivered-instruction counter
        tick();
        rst_n = 1'b0;
        at_neg();
        chk("perf_reset", perf_fetch_cnt, 32'd0);
        tick();
        rst_n    = 1'b1;
        id_ready = 1'b1;
        hs_base  = id_hs_cnt;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (id_hs_cnt - hs_base >= 5) begin
                break;
            end
        end
        id_ready       = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_3000;
        tick();
        redirect_valid = 1'b0;
        repeat (4) at_neg();
        chk("perf_count_model", perf_fetch_cnt, 32'(id_hs_cnt - hs_base));
        chk("perf_count_five", perf_fetch_cnt, 32'd5);
        tick();
        id_ready = 1'b1;
        repeat (3) tick();
        rst_n = 1'b0;
        at_neg();
        chk("perf_midrun_reset", perf_fetch_cnt, 32'd0);
        tick();
        rst_n = 1'b1;
`endif

        tick();
        id_ready = 1'b1;
        repeat (10) at_neg();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
